pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (F/D, D/E, E/M, M/W) for the 5-stage MIPS core.
//  - Carries PC, an opaque payload and register-writeback side-band under a valid/ready handshake.
//  - Supports synchronous flush and backpressure, so hazard logic drives stall/flush per stage.
//  - Optional 1-entry skid buffer makes in_ready a pure register output, breaking the ready path.

---
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying PC, payload and writeback side-band.
// Define PIPE_SKID_EN to add a 1-entry skid buffer so that in_ready is a pure flop output.
module pipe_stage_reg #(
  parameter int              DATA_W   = 128,
  parameter int              PC_W     = 32,
  parameter int              RA_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_reg_we,
  input  logic [RA_W-1:0]   in_reg_wa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_reg_we,
  output logic [RA_W-1:0]   out_reg_wa
);

  // Handshake: a beat transfers on a side only in a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready, and a held beat stays stable.
  logic accept;
  logic consume;

  logic              main_valid_q, main_valid_d;
  logic [PC_W-1:0]   main_pc_q,    main_pc_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              main_we_q,    main_we_d;
  logic [RA_W-1:0]   main_wa_q,    main_wa_d;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              skid_we_q,    skid_we_d;
  logic [RA_W-1:0]   skid_wa_q,    skid_wa_d;
  logic              in_ready_q,   in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !main_valid_q | out_ready;
`endif

  assign accept  = in_valid & in_ready;
  assign consume = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_data_d  = main_data_q;
    main_we_d    = main_we_q;
    main_wa_d    = main_wa_q;
`ifdef PIPE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_data_d  = skid_data_q;
    skid_we_d    = skid_we_q;
    skid_wa_d    = skid_wa_q;

    if (!main_valid_q || consume) begin
      // Skid only fills while main is full, so draining it first preserves order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc_q;
        main_data_d  = skid_data_q;
        main_we_d    = skid_we_q;
        main_wa_d    = skid_wa_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_pc_d    = in_pc;
        main_data_d  = in_data;
        main_we_d    = in_reg_we;
        main_wa_d    = in_reg_wa;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_data_d  = in_data;
      skid_we_d    = in_reg_we;
      skid_wa_d    = in_reg_wa;
    end
`else
    if (accept) begin
      main_valid_d = 1'b1;
      main_pc_d    = in_pc;
      main_data_d  = in_data;
      main_we_d    = in_reg_we;
      main_wa_d    = in_reg_wa;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
`endif

    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = RESET_PC;
      main_we_d    = 1'b0;
`ifdef PIPE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end

`ifdef PIPE_SKID_EN
    in_ready_d = !skid_valid_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= RESET_PC;
      main_data_q  <= '0;
      main_we_q    <= 1'b0;
      main_wa_q    <= '0;
`ifdef PIPE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_pc_q    <= RESET_PC;
      skid_data_q  <= '0;
      skid_we_q    <= 1'b0;
      skid_wa_q    <= '0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_data_q  <= main_data_d;
      main_we_q    <= main_we_d;
      main_wa_q    <= main_wa_d;
`ifdef PIPE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_data_q  <= skid_data_d;
      skid_we_q    <= skid_we_d;
      skid_wa_q    <= skid_wa_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  // Register $0 is never written, so the enable is gated on the address as well.
  assign out_valid  = main_valid_q;
  assign out_pc     = main_pc_q;
  assign out_data   = main_data_q;
  assign out_reg_wa = main_wa_q;
  assign out_reg_we = main_we_q & main_valid_q & (main_wa_q != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench for pipe_stage_reg: directed beats, stalls, flush, $0 gating and reset.
module tb_pipe_stage_reg;
  localparam int DATA_W = 128;
  localparam int PC_W   = 32;
  localparam int RA_W   = 5;
  localparam int BW     = PC_W + DATA_W + 1 + RA_W;
`ifdef PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              in_valid, in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              in_reg_we;
  logic [RA_W-1:0]   in_reg_wa;
  logic              out_valid, out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic              out_reg_we;
  logic [RA_W-1:0]   out_reg_wa;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] e;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic acc, b_taken;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required simulation to finish");
    $fatal(1, "watchdog");
  end

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_reg_we(in_reg_we), .in_reg_wa(in_reg_wa),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_reg_we(out_reg_we), .out_reg_wa(out_reg_wa)
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [PC_W-1:0] pc);
    return {pc, ~pc, pc ^ 32'hA5A5_A5A5, 32'hC0DE_0000 | pc};
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic we, input logic [RA_W-1:0] wa);
    in_valid  = v;
    in_pc     = pc;
    in_data   = mk_data(pc);
    in_reg_we = we;
    in_reg_wa = wa;
  endtask

  task automatic tick(output logic accepted);
    @(negedge clk);
    accepted = in_valid && in_ready && !flush && !rst;
    if (rst || flush) exp_q.delete();
    else if (accepted) exp_q.push_back({in_pc, in_data, in_reg_we && (in_reg_wa != '0), in_reg_wa});
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: actual out_pc=%h, required no beat", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("beat_pc",   out_pc,     e[BW-1 -: PC_W]);
        chk("beat_data", out_data,   e[RA_W+DATA_W -: DATA_W]);
        chk("beat_we",   out_reg_we, e[RA_W]);
        chk("beat_wa",   out_reg_wa, e[RA_W-1:0]);
      end
      delivered++;
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    tick(acc);
    tick(acc);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 32'h3000);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_reg_we", out_reg_we, 0);
    chk("rst_in_ready", in_ready, 1);

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC_W'(32'h3000 + 4 * i), 1'(i), RA_W'(i + 1));
      #1;
      chk("stream_in_ready", in_ready, 1);
      if (i > 0) chk("stream_out_pc", out_pc, 32'h3000 + 4 * (i - 1));
      tick(acc);
    end
    in_valid = 1'b0;
    #1;
    chk("stream_last_valid", out_valid, 1);
    chk("stream_last_pc", out_pc, 32'h300C);
    tick(acc);
    tick(acc);

    // stall with A held and B offered
    out_ready = 1'b0;
    drive(1'b1, 32'h4000, 1'b1, 5'd7);
    tick(acc);
    drive(1'b1, 32'h4004, 1'b0, 5'd8);
    b_taken = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_hold_pc", out_pc, 32'h4000);
      chk("stall_hold_data", out_data, mk_data(32'h4000));
      chk("stall_in_ready", in_ready, (c == 0) ? SKID : 1'b0);
      tick(acc);
      if (acc) begin b_taken = 1'b1; in_valid = 1'b0; end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4 && !b_taken; c++) begin
      tick(acc);
      if (acc) begin b_taken = 1'b1; in_valid = 1'b0; end
    end
    chk("stall_b_accepted", b_taken, 1);
    tick(acc);
    tick(acc);
    #1;
    chk("stall_drained", out_valid, 0);
    chk("stall_delivered", delivered, 6);

    // flush while A held and B offered
    out_ready = 1'b0;
    drive(1'b1, 32'h5000, 1'b1, 5'd3);
    tick(acc);
    drive(1'b1, 32'h5004, 1'b1, 5'd4);
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_pc", out_pc, 32'h3000);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_reg_we", out_reg_we, 0);
    out_ready = 1'b1;
    tick(acc);
    tick(acc);
    tick(acc);
    chk("flush_delivered", delivered, 6);

    // $0 writeback gating and bubble behaviour
    out_ready = 1'b0;
    drive(1'b1, 32'h6000, 1'b1, 5'd0);
    tick(acc);
    in_valid = 1'b0;
    #1;
    chk("wa0_valid", out_valid, 1);
    chk("wa0_reg_we", out_reg_we, 0);
    chk("wa0_reg_wa", out_reg_wa, 0);
    out_ready = 1'b1;
    tick(acc);
    out_ready = 1'b0;
    drive(1'b1, 32'h6004, 1'b1, 5'd5);
    tick(acc);
    in_valid = 1'b0;
    #1;
    chk("wa5_reg_we", out_reg_we, 1);
    chk("wa5_reg_wa", out_reg_wa, 5);
    out_ready = 1'b1;
    tick(acc);
    #1;
    chk("bubble_valid", out_valid, 0);
    chk("bubble_reg_we", out_reg_we, 0);
    chk("bubble_keeps_pc", out_pc, 32'h6004);
    chk("bubble_keeps_data", out_data, mk_data(32'h6004));
    chk("wa_delivered", delivered, 8);

    // reset mid-stall with both entries occupied
    out_ready = 1'b0;
    drive(1'b1, 32'h7000, 1'b1, 5'd9);
    tick(acc);
    drive(1'b1, 32'h7004, 1'b1, 5'd10);
    tick(acc);
    #1;
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_pc", out_pc, 32'h3000);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_out_reg_we", out_reg_we, 0);
    chk("rst2_out_reg_wa", out_reg_wa, 0);
    chk("rst2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick(acc);
    tick(acc);
    tick(acc);
    chk("final_delivered", delivered, 8);
    chk("final_queue_empty", exp_q.size(), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
